// File: rtl/store_buffer.sv
// Committed-store FIFO that drains one word at a time to the data cache and forwards to younger loads.
// Latency: a store reaches dmem two cycles after enqueue into an empty buffer; load lookup is same-cycle combinational.
// Backpressure: enq_ready drops when all SB_DEPTH entries are occupied; drain holds its request until dmem_resp. Optional: SB_FORWARD_EN.
module store_buffer #(
    parameter int SB_DEPTH = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [ADDR_W-1:0]           enq_addr,
    input  logic [DATA_W-1:0]           enq_data,
    input  logic [DATA_W/8-1:0]         enq_mask,
    output logic [ADDR_W-1:0]           dmem_addr,
    output logic [DATA_W-1:0]           dmem_wdata,
    output logic [DATA_W/8-1:0]         dmem_wmask,
    input  logic                        dmem_resp,
    input  logic [ADDR_W-1:0]           ld_addr,
    input  logic [DATA_W/8-1:0]         ld_rmask,
    output logic                        ld_fwd_hit,
    output logic [DATA_W-1:0]           ld_fwd_data,
    output logic                        ld_stall,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    output logic                        sb_empty
);
    localparam int IW = $clog2(SB_DEPTH);
    localparam int MW = DATA_W / 8;
    localparam int WW = ADDR_W - 2;

    typedef enum logic {IDLE, WAIT} drain_t;

    drain_t                state;
    logic [WW-1:0]         e_addr [SB_DEPTH];
    logic [DATA_W-1:0]     e_data [SB_DEPTH];
    logic [MW-1:0]         e_mask [SB_DEPTH];
    logic [SB_DEPTH-1:0]   e_sent;
    logic [IW:0]           head;
    logic [IW:0]           tail;
    logic [IW:0]           cnt;
    logic [IW-1:0]         h_idx;
    logic [IW-1:0]         t_idx;
    logic                  full;
    logic                  empty;
    logic                  do_enq;
    logic                  do_pop;
    logic                  enq_hit;
    logic                  m_found;
    logic [MW-1:0]         m_mask;
    logic [DATA_W-1:0]     m_data;
    logic [IW-1:0]         l_idx;
    logic                  unused_lsb;

    assign h_idx     = head[IW-1:0];
    assign t_idx     = tail[IW-1:0];
    assign full      = (head[IW] != tail[IW]) && (h_idx == t_idx);
    assign empty     = (head == tail);
    assign enq_ready = !full;
    assign do_enq    = enq_valid && !full;
    assign do_pop    = (state == WAIT) && dmem_resp;
    assign sb_count  = cnt;
    assign sb_empty  = empty;
    assign enq_hit   = enq_valid && (enq_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]);
    // Byte offsets inside a word are irrelevant: matching and draining are word-granular.
    assign unused_lsb = ^{enq_addr[1:0], ld_addr[1:0]};

    // Entry payload write; no reset needed since occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            e_addr[t_idx] <= enq_addr[ADDR_W-1:2];
            e_data[t_idx] <= enq_data;
            e_mask[t_idx] <= enq_mask;
        end
    end

    // Pointers, occupancy and the two-state drain FSM with registered cache request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            state      <= IDLE;
            e_sent     <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
        end else begin
            if (do_enq) begin
                tail          <= tail + 1'b1;
                e_sent[t_idx] <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!empty && !e_sent[h_idx]) begin
                        state         <= WAIT;
                        e_sent[h_idx] <= 1'b1;
                        dmem_addr     <= {e_addr[h_idx], 2'b00};
                        dmem_wdata    <= e_data[h_idx];
                        dmem_wmask    <= e_mask[h_idx];
                    end
                end
                WAIT: begin
                    if (dmem_resp) begin
                        state      <= IDLE;
                        head       <= head + 1'b1;
                        dmem_wmask <= '0;
                    end
                end
            endcase
            if (do_enq && !do_pop) begin
                cnt <= cnt + 1'b1;
            end else if (!do_enq && do_pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Walk occupied entries oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        m_found = 1'b0;
        m_mask  = '0;
        m_data  = '0;
        l_idx   = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            l_idx = h_idx + IW'(k);
            if (((IW+1)'(k) < cnt) && (e_addr[l_idx] == ld_addr[ADDR_W-1:2])) begin
                m_found = 1'b1;
                m_mask  = e_mask[l_idx];
                m_data  = e_data[l_idx];
            end
        end
    end

`ifdef SB_FORWARD_EN
    // Forward only when the youngest match covers every requested byte; anything less must retry.
    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        ld_stall    = 1'b0;
        if (ld_rmask != '0) begin
            if (enq_hit) begin
                ld_stall = 1'b1;
            end else if (m_found) begin
                if ((m_mask & ld_rmask) == ld_rmask) begin
                    ld_fwd_hit  = 1'b1;
                    ld_fwd_data = m_data;
                end else begin
                    ld_stall = 1'b1;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd  = ^{m_mask, m_data};
    assign ld_fwd_hit  = 1'b0;
    assign ld_fwd_data = '0;
    // Without forwarding any same-word store, buffered or arriving, blocks the load.
    assign ld_stall    = (ld_rmask != '0) && (enq_hit || m_found);
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 8, number of buffered committed stores (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, store data width; mask width DATA_W/8.
REQ-004 SHALL have ports as follows:
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset.
- enq_valid  input  1  committed store presented.
- enq_ready  output  1  buffer can accept.
- enq_addr  input  ADDR_W  store byte address.
- enq_data  input  DATA_W  store data, lane-aligned.
- enq_mask  input  DATA_W/8  byte write mask.
- dmem_addr  output  ADDR_W  drain address, word-aligned.
- dmem_wdata  output  DATA_W  drain data.
- dmem_wmask  output  DATA_W/8  drain mask; nonzero means request valid.
- dmem_resp  input  1  cache write complete.
- ld_addr  input  ADDR_W  load lookup address.
- ld_rmask  input  DATA_W/8  load byte mask; zero means no lookup.
- ld_fwd_hit  output  1  load fully satisfied from buffer.
- ld_fwd_data  output  DATA_W  forwarded data.
- ld_stall  output  1  load must retry.
- sb_count  output  $clog2(SB_DEPTH)+1  occupied entries.
- sb_empty  output  1  no entries.

Function
REQ-005 SHALL be a circular FIFO; head and tail pointers carry one extra wrap bit; full when indices equal and wrap bits differ, empty when pointers equal.
REQ-006 SHALL drive enq_ready = !full; enqueue occurs when enq_valid && enq_ready. A pop in the same cycle SHALL NOT make a full buffer ready.
REQ-007 SHALL store each entry as {addr, data, mask, sent_to_cache}; sent_to_cache clears on enqueue.
REQ-008 SHALL have two drain states: IDLE and WAIT. IDLE->WAIT when not empty, setting head sent_to_cache. WAIT->IDLE on dmem_resp, popping head.
REQ-009 SHALL drive dmem_addr/wdata/wmask from the head entry in WAIT and hold them stable until dmem_resp; dmem_wmask SHALL be zero in IDLE.
REQ-010 SHALL ignore dmem_resp in IDLE.
REQ-011 SHALL update sb_count each cycle by +1 on enqueue, -1 on pop, unchanged if both or neither.
REQ-012 SHALL compare word addresses (ld_addr[ADDR_W-1:2]) against all valid entries, including the head in WAIT; lookup is combinational, same-cycle.
REQ-013 SHALL select only the youngest matching entry. If its mask covers every ld_rmask bit: ld_fwd_hit=1, ld_fwd_data=its data. If it covers only some bits: ld_stall=1, ld_fwd_hit=0.
REQ-014 SHALL assert ld_stall when enq_valid and enq_addr matches the lookup word, regardless of masks.
REQ-015 SHALL drive ld_fwd_hit=0 and ld_stall=0 when ld_rmask is zero or nothing matches; ld_fwd_data SHALL then be zero.
REQ-016 SHALL retain pointer wrap correctly across SB_DEPTH boundaries with no entry loss.

Reset
REQ-017 SHALL, when rst=0 at a clock edge, clear pointers, sb_count=0, sb_empty=1, state=IDLE, all sent_to_cache=0, and dmem_wmask=0; enq_ready=1 on the following cycle.
REQ-018 SHALL abandon an in-flight drain on reset mid-WAIT; a later dmem_resp SHALL be ignored.

Configuration
REQ-019 SHALL define macro SB_FORWARD_EN. With it defined, REQ-013 applies. Without it, ld_fwd_hit=0 and ld_fwd_data=0 always, and any word-address match asserts ld_stall.

Verification
REQ-020 SHALL cover fill-to-full: enqueue 8 stores with dmem_resp=0 -> enq_ready=0 after the 8th, sb_count=8, and the 9th is refused.
REQ-021 SHALL cover drain order: enqueue addrs 0x100, 0x104, with a resp 1 cycle after each request -> dmem_addr 0x100, then 0x104; sb_empty=1 afterwards.
REQ-022 SHALL cover forwarding: sw 0x200=0xAAAAAAAA then sw 0x200=0x12345678, load 0x200 mask 0xF -> hit, data 0x12345678.
REQ-023 SHALL cover partial overlap: sb 0x300 mask 0x1, load 0x300 mask 0xF -> ld_stall=1, hit=0; without SB_FORWARD_EN, full-overlap load also stalls.
REQ-024 SHALL cover wrap and simultaneity: 20 stores streamed with enqueue and pop in the same cycle -> sb_count stays constant and all 20 drain in order.
REQ-025 SHALL cover reset mid-WAIT: rst=0 while head is in WAIT -> sb_count=0 and dmem_wmask=0 next cycle.
